qam16_rx_checker: RTL and testbench

QAM16_RX_CHECKER -- requirements
Module: qam16_rx_checker

---
 rtl/qam16_rx_checker.sv | 211 +++++++++++++++++++++
 tb/tb_qam16_rx_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_rx_checker.sv
// qam16_rx_checker: symbol decimator, 16-QAM Gray slicer and self-synchronizing PRBS-23 bit-error checker.
// Latency: bits_valid 2 clocks after the selected rx_valid sample; sym_err/locked/counters 1 clock after bits_valid.
// Backpressure: none; one sample per clock is accepted whenever rx_valid is high, the block never stalls.
//
// Ports:
//   clk, rst_n           sole clock (posedge) and asynchronous active-low reset
//   rx_I, rx_Q, rx_valid matched-filter samples (signed Q1.11) and their qualifier
//   sym_phase            which of each SPS valid samples is taken as the symbol
//   clr                  synchronous clear of err_cnt / bit_cnt
//   bits_out, bits_valid demapped {I1,I0,Q1,Q0} and its one-clock strobe
//   locked, sym_err      checker lock state and per-symbol error pulse
//   err_cnt, bit_cnt     saturating bit-error / checked-bit counts while locked
module qam16_rx_checker #(
  parameter logic signed [11:0] SLICE_THR   = 12'sd1024,
  parameter int                 LOCK_SYMS   = 16,
  parameter int                 UNLOCK_SYMS = 4,
  parameter int                 CNT_W       = 32,
  parameter int                 SPS         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [11:0]     rx_I,
  input  logic signed [11:0]     rx_Q,
  input  logic                   rx_valid,
  input  logic [$clog2(SPS)-1:0] sym_phase,
  input  logic                   clr,
  output logic [3:0]             bits_out,
  output logic                   bits_valid,
  output logic                   locked,
  output logic                   sym_err,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       bit_cnt
);

  localparam int PH_W = $clog2(SPS);
  localparam int LC_W = $clog2(LOCK_SYMS + 1);
  localparam int UC_W = $clog2(UNLOCK_SYMS + 1);
  localparam logic signed [11:0] NEG_THR = -SLICE_THR;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------- decimator
  logic [PH_W-1:0]    r_dec_cnt;
  logic signed [11:0] r_dec_I;
  logic signed [11:0] r_dec_Q;
  logic               r_dec_vld;
  logic               w_take;

  // sym_phase is compared live, so a phase change takes effect at the next
  // comparison without disturbing the running sample counter.
  assign w_take = rx_valid && (r_dec_cnt == sym_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_dec_I   <= '0;
      r_dec_Q   <= '0;
      r_dec_vld <= 1'b0;
    end else begin
      r_dec_vld <= w_take;
      if (w_take) begin
        r_dec_I <= rx_I;
        r_dec_Q <= rx_Q;
      end
      if (rx_valid) begin
        r_dec_cnt <= (r_dec_cnt == PH_W'(SPS - 1)) ? '0 : r_dec_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ slicer
  // Gray map per axis: outer+ 10, inner+ 11, inner- 01, outer- 00.
  function automatic logic [1:0] slice(input logic signed [11:0] x);
    if (x >= SLICE_THR)     return 2'b10;
    else if (x >= 12'sd0)   return 2'b11;
    else if (x >= NEG_THR)  return 2'b01;
    else                    return 2'b00;
  endfunction

  logic [3:0] r_bits;
  logic       r_bits_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits     <= '0;
      r_bits_vld <= 1'b0;
    end else begin
      r_bits_vld <= r_dec_vld;
      if (r_dec_vld) begin
        r_bits <= {slice(r_dec_I), slice(r_dec_Q)};
      end
    end
  end

  assign bits_out   = r_bits;
  assign bits_valid = r_bits_vld;

  // ------------------------------------------------------------ PRBS checker
  // The register holds received bits (newest in bit 0), so any channel error
  // is seen three times: on arrival and again at taps 18 and 23.
  logic [22:0] r_prbs;
  logic [22:0] w_prbs_nxt;
  logic [3:0]  w_mis;
  logic [2:0]  w_pop;
  logic        w_sym_bad;

  always_comb begin
    w_prbs_nxt = r_prbs;
    w_mis      = '0;
    for (int i = 3; i >= 0; i--) begin
      w_mis[i]   = r_bits[i] ^ w_prbs_nxt[22] ^ w_prbs_nxt[17];
      w_prbs_nxt = {w_prbs_nxt[21:0], r_bits[i]};
    end
    w_pop = {2'b00, w_mis[0]} + {2'b00, w_mis[1]} + {2'b00, w_mis[2]} + {2'b00, w_mis[3]};
  end

  assign w_sym_bad = |w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prbs <= '0;
    end else if (r_bits_vld) begin
      r_prbs <= w_prbs_nxt;
    end
  end

  // --------------------------------------------------------------- lock FSM
  state_t          r_state;
  logic [LC_W-1:0] r_good_cnt;
  logic [UC_W-1:0] r_bad_cnt;
  logic            r_locked;
  logic            r_sym_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_locked   <= 1'b0;
      r_sym_err  <= 1'b0;
    end else begin
      r_sym_err <= r_bits_vld && w_sym_bad;
      if (r_bits_vld) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_sym_bad) begin
              r_good_cnt <= '0;
            end else if (r_good_cnt == LC_W'(LOCK_SYMS - 1)) begin
              r_good_cnt <= '0;
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
            end else begin
              r_good_cnt <= r_good_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!w_sym_bad) begin
              r_bad_cnt <= '0;
            end else if (r_bad_cnt == UC_W'(UNLOCK_SYMS - 1)) begin
              r_bad_cnt <= '0;
              r_state   <= ST_SEARCH;
              r_locked  <= 1'b0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked  = r_locked;
  assign sym_err = r_sym_err;

  // --------------------------------------------------------- error counters
  // Gated on the state before this symbol's transition: the locking symbol is
  // excluded, the unlocking symbol is included.
  logic             w_count;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W:0]   w_bit_sum;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_bit_cnt;

  assign w_count   = r_bits_vld && (r_state == ST_LOCKED);
  assign w_err_sum = {1'b0, r_err_cnt} + {{(CNT_W - 2){1'b0}}, w_pop};
  assign w_bit_sum = {1'b0, r_bit_cnt} + (CNT_W + 1)'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_count) begin
      r_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
      r_bit_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    end
  end

  assign err_cnt = r_err_cnt;
  assign bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_qam16_rx_checker.sv
// tb_qam16_rx_checker: directed checks of decimator, slicer, PRBS lock/unlock and counters.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there (away from edge).
// Backpressure: n/a; the bench drives one sample per clock with optional idle gaps.
module tb_qam16_rx_checker;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] rx_I;
  logic signed [11:0] rx_Q;
  logic               rx_valid;
  logic [1:0]         sym_phase;
  logic               clr;

  logic [3:0]  bits_out,   bits_out8;
  logic        bits_valid, bits_valid8;
  logic        locked,     locked8;
  logic        sym_err,    sym_err8;
  logic [31:0] err_cnt,    bit_cnt;
  logic [7:0]  err_cnt8,   bit_cnt8;

  always #5 clk = ~clk;

  qam16_rx_checker u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_I       (rx_I),
    .rx_Q       (rx_Q),
    .rx_valid   (rx_valid),
    .sym_phase  (sym_phase),
    .clr        (clr),
    .bits_out   (bits_out),
    .bits_valid (bits_valid),
    .locked     (locked),
    .sym_err    (sym_err),
    .err_cnt    (err_cnt),
    .bit_cnt    (bit_cnt)
  );

  qam16_rx_checker #(.CNT_W(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_I       (rx_I),
    .rx_Q       (rx_Q),
    .rx_valid   (rx_valid),
    .sym_phase  (sym_phase),
    .clr        (clr),
    .bits_out   (bits_out8),
    .bits_valid (bits_valid8),
    .locked     (locked8),
    .sym_err    (sym_err8),
    .err_cnt    (err_cnt8),
    .bit_cnt    (bit_cnt8)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int n_sym_err = 0;
  int base;

  // PRBS-23 stream: seed bits 1,0...0 then b[n] = b[n-23] ^ b[n-18].
  logic prbs [0:511];

  always @(negedge clk) if (sym_err) n_sym_err++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [11:0] lvl(input logic [1:0] g);
    case (g)
      2'b10:   return 12'sd1536;
      2'b11:   return 12'sd512;
      2'b01:   return -12'sd512;
      default: return -12'sd1536;
    endcase
  endfunction

  task automatic drive(input logic v, input logic signed [11:0] i, input logic signed [11:0] q);
    rx_valid = v;
    rx_I     = i;
    rx_Q     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic signed [11:0] i, input logic signed [11:0] q);
    drive(1'b1, i, q);
    repeat (3) drive(1'b1, 12'sd0, 12'sd0);
  endtask

  // One PRBS symbol (phase 0): optional bit flips, idle gaps, and clr in the bits_valid cycle.
  task automatic send_prbs(input int k, input logic [3:0] flip, input bit gaps, input bit clr3);
    logic [3:0] b;
    b = {prbs[4*k], prbs[4*k+1], prbs[4*k+2], prbs[4*k+3]} ^ flip;
    for (int s = 0; s < 4; s++) begin
      clr = clr3 && (s == 2);
      if (s == 0) drive(1'b1, lvl(b[3:2]), lvl(b[1:0]));
      else        drive(1'b1, 12'sd0, 12'sd0);
      clr = 1'b0;
      if (gaps) repeat ($urandom_range(3, 1)) drive(1'b0, 12'sh800, 12'sd2047);
    end
    chk("bits_out", 32'(bits_out), 32'(b));
  endtask

  task automatic send_range(input int k0, input int k1, input bit gaps);
    for (int k = k0; k <= k1; k++) send_prbs(k, 4'b0000, gaps, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int n = 0; n < 23; n++) prbs[n] = (n == 0);
    for (int n = 23; n < 512; n++) prbs[n] = prbs[n-23] ^ prbs[n-18];

    rst_n = 1'b0; rx_valid = 1'b0; rx_I = '0; rx_Q = '0; sym_phase = 2'd0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bits_out",   32'(bits_out),   32'd0);
    chk("rst_bits_valid", 32'(bits_valid), 32'd0);
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_sym_err",    32'(sym_err),    32'd0);
    chk("rst_err_cnt",    err_cnt,         32'd0);
    chk("rst_bit_cnt",    bit_cnt,         32'd0);
    rst_n = 1'b1;

    // Slicer and latency.
    drive(1'b1, 12'sd1500, -12'sd200);
    chk("bv_lat1", 32'(bits_valid), 32'd0);
    drive(1'b1, 12'sd0, 12'sd0);
    chk("bv_lat2", 32'(bits_valid), 32'd1);
    chk("slice_1500_m200", 32'(bits_out), 32'b1001);
    drive(1'b1, 12'sd0, 12'sd0);
    chk("bv_pulse", 32'(bits_valid), 32'd0);
    drive(1'b1, 12'sd0, 12'sd0);
    chk("bits_hold", 32'(bits_out), 32'b1001);
    send_sym(-12'sd1024, 12'sd1024);
    chk("slice_m1024_p1024", 32'(bits_out), 32'b0110);
    send_sym(-12'sd1025, 12'sd1023);
    chk("slice_m1025_p1023", 32'(bits_out), 32'b0011);
    send_sym(12'sd2047, 12'sh800);
    chk("slice_extremes", 32'(bits_out), 32'b1000);
    send_sym(12'sd0, -12'sd1);
    chk("slice_zero_m1", 32'(bits_out), 32'b1101);

    // Phase selection, valid gaps, live phase change.
    sym_phase = 2'd2;
    drive(1'b1, 12'sd100, 12'sd100);
    drive(1'b1, -12'sd1500, 12'sd1500);
    drive(1'b1, -12'sd100, -12'sd1500);
    drive(1'b1, 12'sd1500, 12'sd1500);
    chk("phase2", 32'(bits_out), 32'b0100);
    drive(1'b1, 12'sd1500, 12'sd1500);
    drive(1'b0, -12'sd100, -12'sd1500);
    drive(1'b1, -12'sd1500, -12'sd1500);
    drive(1'b0, -12'sd100, -12'sd1500);
    drive(1'b1, 12'sd500, -12'sd100);
    drive(1'b0, -12'sd100, -12'sd1500);
    drive(1'b1, -12'sd1500, 12'sd1500);
    chk("phase2_gap", 32'(bits_out), 32'b1101);
    sym_phase = 2'd1;
    drive(1'b1, 12'sd1500, 12'sd1500);
    drive(1'b1, -12'sd500, 12'sd500);
    drive(1'b1, 12'sd0, 12'sd0);
    drive(1'b1, 12'sd0, 12'sd0);
    chk("phase1_change", 32'(bits_out), 32'b0111);
    sym_phase = 2'd0;

    // PRBS lock: symbol 0 and 4 errored, 5..20 clean -> lock on symbol 20.
    do_reset();
    send_range(0, 19, 1'b0);
    chk("lock_early", 32'(locked), 32'd0);
    send_prbs(20, 4'b0000, 1'b0, 1'b0);
    chk("lock_at20", 32'(locked), 32'd1);
    chk("lock_sym_uncounted", bit_cnt, 32'd0);
    send_range(21, 28, 1'b0);
    chk("bit_cnt_8sym", bit_cnt, 32'd32);
    chk("err_cnt_clean", err_cnt, 32'd0);
    send_range(29, 40, 1'b1);
    chk("bit_cnt_gaps", bit_cnt, 32'd80);
    chk("locked_gaps", 32'(locked), 32'd1);

    // Single bit flip: mismatches on symbols 41, 45, 46.
    base = n_sym_err;
    send_prbs(41, 4'b1000, 1'b0, 1'b0);
    chk("flip_err1", err_cnt, 32'd1);
    chk("flip_symerr1", 32'(n_sym_err - base), 32'd1);
    send_range(42, 46, 1'b0);
    chk("flip_err3", err_cnt, 32'd3);
    chk("flip_symerr3", 32'(n_sym_err - base), 32'd3);
    chk("flip_locked", 32'(locked), 32'd1);
    chk("flip_bit_cnt", bit_cnt, 32'd104);
    send_range(47, 50, 1'b0);
    chk("bit_cnt_120", bit_cnt, 32'd120);

    // Four corrupted symbols -> unlock on the 4th, which is still counted.
    for (int k = 51; k <= 53; k++) send_prbs(k, 4'b1111, 1'b0, 1'b0);
    chk("unlock_not_yet", 32'(locked), 32'd1);
    chk("err_cnt_15", err_cnt, 32'd15);
    send_prbs(54, 4'b1111, 1'b0, 1'b0);
    chk("unlock_at4", 32'(locked), 32'd0);
    chk("err_cnt_19", err_cnt, 32'd19);
    chk("bit_cnt_136", bit_cnt, 32'd136);
    send_range(55, 75, 1'b0);
    chk("frozen_locked", 32'(locked), 32'd0);
    chk("frozen_bit", bit_cnt, 32'd136);
    chk("frozen_err", err_cnt, 32'd19);
    send_prbs(76, 4'b0000, 1'b0, 1'b0);
    chk("relock_76", 32'(locked), 32'd1);
    chk("relock_uncounted", bit_cnt, 32'd136);

    // clr in the same cycle as an increment.
    send_prbs(77, 4'b0000, 1'b0, 1'b1);
    chk("clr_bit", bit_cnt, 32'd0);
    chk("clr_err", err_cnt, 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);
    send_prbs(78, 4'b0000, 1'b0, 1'b0);
    chk("after_clr_bit", bit_cnt, 32'd4);
    chk("after_clr_err", err_cnt, 32'd0);

    // Reset while locked with a sample in flight.
    drive(1'b1, 12'sd1536, 12'sd1536);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_bits_out", 32'(bits_out), 32'd0);
    chk("mrst_bits_valid", 32'(bits_valid), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_sym_err", 32'(sym_err), 32'd0);
    chk("mrst_err", err_cnt, 32'd0);
    chk("mrst_bit", bit_cnt, 32'd0);
    do_reset();
    send_range(0, 19, 1'b0);
    chk("mrst_lock_early", 32'(locked), 32'd0);
    send_prbs(20, 4'b0000, 1'b0, 1'b0);
    chk("mrst_relock", 32'(locked), 32'd1);

    // 8-bit counter saturation.
    send_range(21, 83, 1'b0);
    chk("sat8_252", 32'(bit_cnt8), 32'd252);
    chk("wide_252", bit_cnt, 32'd252);
    send_prbs(84, 4'b0000, 1'b0, 1'b0);
    chk("sat8_255", 32'(bit_cnt8), 32'd255);
    chk("wide_256", bit_cnt, 32'd256);
    send_range(85, 90, 1'b0);
    chk("sat8_hold", 32'(bit_cnt8), 32'd255);
    chk("wide_280", bit_cnt, 32'd280);
    chk("sat8_err", 32'(err_cnt8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
